// File: rtl/riscv_pkg.sv
// RV32I encodings, ALU op codes and the decoded-control record shared by the
// decode stage and the ALU.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
   typedef enum logic [2:0] {B_RS2, B_IMM_I, B_SHAMT, B_IMM_S, B_IMM_U, B_FOUR} b_sel_t;

   typedef struct packed {
      logic [3:0] alu_op;
      a_sel_t     a_sel;
      b_sel_t     b_sel;
      logic       rd_we;
      logic       mem_re;
      logic       mem_we;
      logic       branch;
      logic       jump;
      logic       illegal;
   } ctrl_t;

   // Raw decode of one instruction word; the caller decides what an illegal
   // beat is allowed to drive.
   function automatic ctrl_t decode(input logic [31:0] instr);
      ctrl_t      c;
      logic [6:0] opcode;
      logic [6:0] f7;
      logic [2:0] f3;
      opcode    = instr[6:0];
      f7        = instr[31:25];
      f3        = instr[14:12];
      c.alu_op  = ALU_ADD;
      c.a_sel   = A_RS1;
      c.b_sel   = B_RS2;
      c.rd_we   = 1'b0;
      c.mem_re  = 1'b0;
      c.mem_we  = 1'b0;
      c.branch  = 1'b0;
      c.jump    = 1'b0;
      c.illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            c.rd_we  = 1'b1;
            c.alu_op = {f7[5], f3};
            if (f7 != F7_BASE && f7 != F7_ALT) c.illegal = 1'b1;
            if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101) c.illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            c.rd_we  = 1'b1;
            c.b_sel  = B_IMM_I;
            c.alu_op = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
            if (f3 == 3'b001) begin
               c.b_sel = B_SHAMT;
               if (f7 != F7_BASE) c.illegal = 1'b1;
            end
            if (f3 == 3'b101) begin
               c.b_sel = B_SHAMT;
               if (f7 != F7_BASE && f7 != F7_ALT) c.illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            c.rd_we  = 1'b1;
            c.mem_re = 1'b1;
            c.b_sel  = B_IMM_I;
         end
         OPC_STORE: begin
            c.mem_we = 1'b1;
            c.b_sel  = B_IMM_S;
         end
         OPC_BRANCH: begin
            c.branch = 1'b1;
            case (f3[2:1])
               2'b00:   c.alu_op = ALU_SUB;
               2'b10:   c.alu_op = ALU_SLT;
               2'b11:   c.alu_op = ALU_SLTU;
               default: c.alu_op = ALU_ADD;
            endcase
         end
         OPC_LUI: begin
            c.rd_we = 1'b1;
            c.a_sel = A_ZERO;
            c.b_sel = B_IMM_U;
         end
         OPC_AUIPC: begin
            c.rd_we = 1'b1;
            c.a_sel = A_PC;
            c.b_sel = B_IMM_U;
         end
         OPC_JAL, OPC_JALR: begin
            c.rd_we = 1'b1;
            c.jump  = 1'b1;
            c.a_sel = A_PC;
            c.b_sel = B_FOUR;
         end
         default: c.illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) c.illegal = 1'b1;
      if (instr[11:7] == 5'd0) c.rd_we = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction for every instruction format.
module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode plus the ID/EX pipeline register feeding the ALU, with a
// valid/ready handshake on both sides and a synchronous flush.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter bit CHECK_ILLEGAL = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [XLEN-1:0] if_pc_i,
   input  logic [31:0]     if_instr_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [3:0]      aluctrl_o,
   output logic [4:0]      rd_o,
   output logic            rd_we_o,
   output logic            mem_re_o,
   output logic            mem_we_o,
   output logic [2:0]      funct3_o,
   output logic [XLEN-1:0] store_data_o,
   output logic            branch_o,
   output logic            jump_o,
   output logic [XLEN-1:0] pc_o,
   output logic            illegal_o
);

   logic            transfer;
   logic            load;
   ctrl_t           ctrl;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] store_data;
   logic            unused_imm;

   imm_gen u_imm_gen (
      .instr (if_instr_i),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // Branch/jump targets are formed downstream, so these two are not needed here.
   assign unused_imm = ^{imm_b, imm_j};

   assign if_ready_o = flush_i | ~ex_valid_o | ex_ready_i;
   assign transfer   = if_valid_i & if_ready_o;
   assign load       = transfer & ~flush_i;

   // NOTE: every field of ctrl is assigned before any conditional override,
   // so no latch can be inferred from this block.
   always_comb begin
      ctrl = decode(if_instr_i);
      if (!CHECK_ILLEGAL) ctrl.illegal = 1'b0;
      if (ctrl.illegal) begin
         ctrl.alu_op = ALU_ADD;
         ctrl.rd_we  = 1'b0;
         ctrl.mem_re = 1'b0;
         ctrl.mem_we = 1'b0;
         ctrl.branch = 1'b0;
         ctrl.jump   = 1'b0;
      end
   end

   always_comb begin
      op_a = rs1_data_i;
      case (ctrl.a_sel)
         A_PC:    op_a = if_pc_i;
         A_ZERO:  op_a = '0;
         default: op_a = rs1_data_i;
      endcase
   end

   always_comb begin
      op_b = rs2_data_i;
      case (ctrl.b_sel)
         B_IMM_I: op_b = imm_i;
         B_SHAMT: op_b = {27'd0, if_instr_i[24:20]};
         B_IMM_S: op_b = imm_s;
         B_IMM_U: op_b = imm_u;
         B_FOUR:  op_b = 32'd4;
         default: op_b = rs2_data_i;
      endcase
   end

   assign store_data = ctrl.mem_we ? rs2_data_i : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_o   <= 1'b0;
         alu_a_o      <= '0;
         alu_b_o      <= '0;
         aluctrl_o    <= '0;
         rd_o         <= '0;
         rd_we_o      <= 1'b0;
         mem_re_o     <= 1'b0;
         mem_we_o     <= 1'b0;
         funct3_o     <= '0;
         store_data_o <= '0;
         branch_o     <= 1'b0;
         jump_o       <= 1'b0;
         pc_o         <= '0;
         illegal_o    <= 1'b0;
      end else begin
         if (flush_i)         ex_valid_o <= 1'b0;
         else if (transfer)   ex_valid_o <= 1'b1;
         else if (ex_ready_i) ex_valid_o <= 1'b0;

         // A flushed beat is accepted but never overwrites the held payload.
         if (load) begin
            alu_a_o      <= op_a;
            alu_b_o      <= op_b;
            aluctrl_o    <= ctrl.alu_op;
            rd_o         <= if_instr_i[11:7];
            rd_we_o      <= ctrl.rd_we;
            mem_re_o     <= ctrl.mem_re;
            mem_we_o     <= ctrl.mem_we;
            funct3_o     <= if_instr_i[14:12];
            store_data_o <= store_data;
            branch_o     <= ctrl.branch;
            jump_o       <= ctrl.jump;
            pc_o         <= if_pc_i;
            illegal_o    <= ctrl.illegal;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a decode vector table plus handshake,
// flush and reset-mid-stall sequences.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic        if_valid_i;
   logic        if_ready_o;
   logic [31:0] if_pc_i;
   logic [31:0] if_instr_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        ex_valid_o;
   logic        ex_ready_i;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [3:0]  aluctrl_o;
   logic [4:0]  rd_o;
   logic        rd_we_o;
   logic        mem_re_o;
   logic        mem_we_o;
   logic [2:0]  funct3_o;
   logic [31:0] store_data_o;
   logic        branch_o;
   logic        jump_o;
   logic [31:0] pc_o;
   logic        illegal_o;

   int n_cmp  = 0;
   int n_fail = 0;

   id_ex_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .if_valid_i   (if_valid_i),
      .if_ready_o   (if_ready_o),
      .if_pc_i      (if_pc_i),
      .if_instr_i   (if_instr_i),
      .rs1_data_i   (rs1_data_i),
      .rs2_data_i   (rs2_data_i),
      .ex_valid_o   (ex_valid_o),
      .ex_ready_i   (ex_ready_i),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .aluctrl_o    (aluctrl_o),
      .rd_o         (rd_o),
      .rd_we_o      (rd_we_o),
      .mem_re_o     (mem_re_o),
      .mem_we_o     (mem_we_o),
      .funct3_o     (funct3_o),
      .store_data_o (store_data_o),
      .branch_o     (branch_o),
      .jump_o       (jump_o),
      .pc_o         (pc_o),
      .illegal_o    (illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        we;
      logic        re;
      logic        st;
      logic        br;
      logic        jp;
      logic        ill;
      logic        chk_ops;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [31:0] instr, pc, rs1, rs2, a, b, sd,
                      input logic [3:0] ctrl, input logic [4:0] rd,
                      input logic we, re, st, br, jp, ill, chk_ops);
      vec_t v;
      v.name = nm;   v.instr = instr; v.pc = pc;  v.rs1 = rs1; v.rs2 = rs2;
      v.a = a;       v.b = b;         v.sd = sd;  v.ctrl = ctrl; v.rd = rd;
      v.we = we;     v.re = re;       v.st = st;  v.br = br;   v.jp = jp;
      v.ill = ill;   v.chk_ops = chk_ops;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [31:0] instr, pc, rs1, rs2);
      if_instr_i = instr;
      if_pc_i    = pc;
      rs1_data_i = rs1;
      rs2_data_i = rs2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ex_valid"}, 32'(ex_valid_o), 32'd0);
      check({tag, ".alu_a"}, alu_a_o, 32'd0);
      check({tag, ".alu_b"}, alu_b_o, 32'd0);
      check({tag, ".aluctrl"}, 32'(aluctrl_o), 32'd0);
      check({tag, ".rd"}, 32'(rd_o), 32'd0);
      check({tag, ".flags"}, 32'({rd_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o}), 32'd0);
      check({tag, ".pc"}, pc_o, 32'd0);
      check({tag, ".store_data"}, store_data_o, 32'd0);
      check({tag, ".funct3"}, 32'(funct3_o), 32'd0);
   endtask

   initial begin
      logic [31:0] held_a;
      logic [31:0] f3_word;

      //   name      instr         pc          rs1          rs2          a            b            sd           ctl  rd we re st br jp il chk
      add("add",    32'h002081B3, 32'h000, 32'h5,        32'h7,        32'h5,        32'h7,        32'h0,        4'h0, 3, 1,0,0,0,0,0,1);
      add("srai",   32'h40335293, 32'h004, 32'h80000000, 32'h55,       32'h80000000, 32'h3,        32'h0,        4'hD, 5, 1,0,0,0,0,0,1);
      add("sub",    32'h403100B3, 32'h008, 32'h10,       32'h3,        32'h10,       32'h3,        32'h0,        4'h8, 1, 1,0,0,0,0,0,1);
      add("xor",    32'h0020C1B3, 32'h00C, 32'hF0,       32'h0F,       32'hF0,       32'h0F,       32'h0,        4'h4, 3, 1,0,0,0,0,0,1);
      add("lui",    32'h123450B7, 32'h010, 32'h999,      32'h888,      32'h0,        32'h12345000, 32'h0,        4'h0, 1, 1,0,0,0,0,0,1);
      add("auipc",  32'h00001117, 32'h100, 32'h999,      32'h888,      32'h100,      32'h1000,     32'h0,        4'h0, 2, 1,0,0,0,0,0,1);
      add("addi",   32'hFFF08213, 32'h104, 32'h10,       32'h0,        32'h10,       32'hFFFFFFFF, 32'h0,        4'h0, 4, 1,0,0,0,0,0,1);
      add("sltiu",  32'hFFF0B293, 32'h108, 32'h1,        32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        4'h3, 5, 1,0,0,0,0,0,1);
      add("srli",   32'h0030D293, 32'h10C, 32'h80000000, 32'h0,        32'h80000000, 32'h3,        32'h0,        4'h5, 5, 1,0,0,0,0,0,1);
      add("lw",     32'h0080A283, 32'h110, 32'h1000,     32'h0,        32'h1000,     32'h8,        32'h0,        4'h0, 5, 1,1,0,0,0,0,1);
      add("sw",     32'h0020A623, 32'h114, 32'h2000,     32'hDEADBEEF, 32'h2000,     32'hC,        32'hDEADBEEF, 4'h0, 12,0,0,1,0,0,0,1);
      add("sw_neg", 32'hFE20AE23, 32'h118, 32'h2000,     32'h12345678, 32'h2000,     32'hFFFFFFFC, 32'h12345678, 4'h0, 28,0,0,1,0,0,0,1);
      add("beq",    32'h00208063, 32'h11C, 32'h3,        32'h3,        32'h3,        32'h3,        32'h0,        4'h8, 0, 0,0,0,1,0,0,1);
      add("blt",    32'h0020C063, 32'h120, 32'h4,        32'h9,        32'h4,        32'h9,        32'h0,        4'h2, 0, 0,0,0,1,0,0,1);
      add("bgeu",   32'h0020F063, 32'h124, 32'h6,        32'h2,        32'h6,        32'h2,        32'h0,        4'h3, 0, 0,0,0,1,0,0,1);
      add("jal",    32'h000000EF, 32'h200, 32'h7,        32'h8,        32'h200,      32'h4,        32'h0,        4'h0, 1, 1,0,0,0,1,0,1);
      add("add_x0", 32'h00208033, 32'h204, 32'h5,        32'h7,        32'h5,        32'h7,        32'h0,        4'h0, 0, 0,0,0,0,0,0,1);
      add("ones",   32'hFFFFFFFF, 32'h208, 32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        4'h0, 31,0,0,0,0,0,1,0);
      add("mul",    32'h022081B3, 32'h20C, 32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        4'h0, 3, 0,0,0,0,0,1,0);
      add("and_alt",32'h4020F1B3, 32'h210, 32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        4'h0, 3, 0,0,0,0,0,1,0);
      add("slli_alt",32'h40309293,32'h214, 32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        4'h0, 5, 0,0,0,0,0,1,0);
      add("low_bits",32'h00208030,32'h218, 32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        4'h0, 0, 0,0,0,0,0,1,0);

      // Reset state
      rst_n = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      #12;
      check_all_zero("reset");
      check("reset.if_ready", 32'(if_ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode table at full throughput
      ex_ready_i = 1'b1;
      if_valid_i = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         @(posedge clk); #1;
         f3_word = vecs[i].instr;
         check({vecs[i].name, ".ex_valid"}, 32'(ex_valid_o), 32'd1);
         if (vecs[i].chk_ops) begin
            check({vecs[i].name, ".alu_a"}, alu_a_o, vecs[i].a);
            check({vecs[i].name, ".alu_b"}, alu_b_o, vecs[i].b);
            check({vecs[i].name, ".store_data"}, store_data_o, vecs[i].sd);
         end
         check({vecs[i].name, ".aluctrl"}, 32'(aluctrl_o), 32'(vecs[i].ctrl));
         check({vecs[i].name, ".rd"}, 32'(rd_o), 32'(vecs[i].rd));
         check({vecs[i].name, ".funct3"}, 32'(funct3_o), 32'(f3_word[14:12]));
         check({vecs[i].name, ".pc"}, pc_o, vecs[i].pc);
         check({vecs[i].name, ".flags[we,re,st,br,jp,ill]"},
               32'({rd_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o}),
               32'({vecs[i].we, vecs[i].re, vecs[i].st, vecs[i].br, vecs[i].jp, vecs[i].ill}));
      end

      // Drain: no new beat, downstream ready
      if_valid_i = 1'b0;
      @(posedge clk); #1;
      check("drain.ex_valid", 32'(ex_valid_o), 32'd0);

      // Backpressure: ADD held for 3 cycles while a SUB waits
      ex_ready_i = 1'b0;
      if_valid_i = 1'b1;
      drive(32'h002081B3, 32'h300, 32'h11, 32'h22);
      @(posedge clk); #1;
      check("bp.load.ex_valid", 32'(ex_valid_o), 32'd1);
      held_a = alu_a_o;
      check("bp.load.alu_a", alu_a_o, 32'h11);
      drive(32'h403100B3, 32'h304, 32'h50, 32'h8);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp.stall%0d.if_ready", c), 32'(if_ready_o), 32'd0);
         @(posedge clk); #1;
         check($sformatf("bp.stall%0d.ex_valid", c), 32'(ex_valid_o), 32'd1);
         check($sformatf("bp.stall%0d.alu_a", c), alu_a_o, held_a);
         check($sformatf("bp.stall%0d.alu_b", c), alu_b_o, 32'h22);
         check($sformatf("bp.stall%0d.pc", c), pc_o, 32'h300);
      end
      ex_ready_i = 1'b1;
      #1;
      check("bp.release.if_ready", 32'(if_ready_o), 32'd1);
      @(posedge clk); #1;
      check("bp.next.ex_valid", 32'(ex_valid_o), 32'd1);
      check("bp.next.pc", pc_o, 32'h304);
      check("bp.next.aluctrl", 32'(aluctrl_o), 32'h8);
      check("bp.next.alu_a", alu_a_o, 32'h50);
      if_valid_i = 1'b0;
      @(posedge clk); #1;
      check("bp.nodup.ex_valid", 32'(ex_valid_o), 32'd0);

      // Flush while a beat is held and another is offered
      ex_ready_i = 1'b0;
      if_valid_i = 1'b1;
      drive(32'h0020C1B3, 32'h400, 32'h1, 32'h2);
      @(posedge clk); #1;
      check("flush.pre.ex_valid", 32'(ex_valid_o), 32'd1);
      drive(32'h123450B7, 32'h404, 32'h0, 32'h0);
      flush_i = 1'b1;
      #1;
      check("flush.if_ready", 32'(if_ready_o), 32'd1);
      @(posedge clk); #1;
      check("flush.ex_valid", 32'(ex_valid_o), 32'd0);
      flush_i    = 1'b0;
      if_valid_i = 1'b0;
      ex_ready_i = 1'b1;
      @(posedge clk); #1;
      check("flush.after.ex_valid", 32'(ex_valid_o), 32'd0);
      check("flush.after.pc_not_new", 32'(pc_o == 32'h404), 32'd0);

      // Asynchronous reset in the middle of a stall
      ex_ready_i = 1'b0;
      if_valid_i = 1'b1;
      drive(32'h000000EF, 32'h500, 32'h3, 32'h4);
      @(posedge clk); #1;
      check("rst.pre.ex_valid", 32'(ex_valid_o), 32'd1);
      if_valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst.mid");
      @(negedge clk);
      rst_n      = 1'b1;
      ex_ready_i = 1'b1;
      @(posedge clk); #1;
      check("rst.noreplay.ex_valid", 32'(ex_valid_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1);
   end

endmodule
